// File: rtl/p6_controller_if.sv
// Control interface between p6_controller and its datapath and instruction source.
// The controller holds the master modport; the datapath/test side holds the slave modport.
interface p6_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        N_in;
  logic        V_in;
  logic        Z_in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic        load_pc;
  logic        pc_sel;
  logic        bad_instr;

  modport master (
    input  in, load, s, N_in, V_in, Z_in,
    output w, readnum, writenum, write, loada, loadb, loadc, loads,
    output asel, bsel, vsel, shift, ALUop, sximm5, sximm8,
    output load_pc, pc_sel, bad_instr
  );

  modport slave (
    output in, load, s, N_in, V_in, Z_in,
    input  w, readnum, writenum, write, loada, loadb, loadc, loads,
    input  asel, bsel, vsel, shift, ALUop, sximm5, sximm8,
    input  load_pc, pc_sel, bad_instr
  );
endinterface

// File: rtl/p6_controller.sv
// Instruction register, decoder and control FSM for p6_datapath.
// Control outputs are registered and decoded from the next state and the executing instruction.
module p6_controller (
  input  logic           clk,
  input  logic           reset,
  p6_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG,
    S_BRANCH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  // Copy of IR taken at start, so a load in the start cycle cannot disturb execution.
  logic [15:0] exec_q, exec_d;

  logic        w_q, w_d;
  logic [2:0]  readnum_q, readnum_d;
  logic [2:0]  writenum_q, writenum_d;
  logic        write_q, write_d;
  logic        loada_q, loada_d;
  logic        loadb_q, loadb_d;
  logic        loadc_q, loadc_d;
  logic        loads_q, loads_d;
  logic        asel_q, asel_d;
  logic [1:0]  vsel_q, vsel_d;
  logic [1:0]  shift_q, shift_d;
  logic [1:0]  aluop_q, aluop_d;
  logic        load_pc_q, load_pc_d;
  logic        bad_instr_q, bad_instr_d;
  logic        taken;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    exec_d      = exec_q;
    bad_instr_d = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        if (bus.load) begin
          ir_d = bus.in;
        end
        if (bus.s) begin
          exec_d = ir_q;
          casez (ir_q[15:11])
            5'b110_10:           state_d = S_WRITE_IMM;
            5'b110_00, 5'b101_11: state_d = S_GET_B;
            5'b101_0?, 5'b101_10: state_d = S_GET_A;
            5'b001_??:           state_d = S_BRANCH;
            default:             bad_instr_d = 1'b1;
          endcase
        end
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (exec_q[15:11] == 5'b101_01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_IMM: state_d = S_WAIT;
      S_WRITE_REG: state_d = S_WAIT;
      S_BRANCH:    state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase

    // Reserved branch conditions are flagged as the branch cycle begins.
    if (state_d == S_BRANCH && exec_d[10:8] > 3'd4) begin
      bad_instr_d = 1'b1;
    end

    w_d        = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 2'b00;
    shift_d    = 2'b00;
    aluop_d    = 2'b00;
    load_pc_d  = 1'b0;

    unique case (state_d)
      S_WAIT: w_d = 1'b1;
      S_WRITE_IMM: begin
        writenum_d = exec_d[10:8];
        vsel_d     = 2'b01;
        write_d    = 1'b1;
      end
      S_GET_A: begin
        readnum_d = exec_d[10:8];
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = exec_d[2:0];
        loadb_d   = 1'b1;
      end
      S_ALU: begin
        shift_d = exec_d[4:3];
        loadc_d = 1'b1;
        // MOV-reg passes B through the ALU by adding it to a zeroed A operand.
        if (exec_d[15:13] == 3'b110) begin
          asel_d  = 1'b1;
          aluop_d = 2'b00;
        end else begin
          aluop_d = exec_d[12:11];
        end
        loads_d = (exec_d[15:11] == 5'b101_01);
      end
      S_WRITE_REG: begin
        writenum_d = exec_d[7:5];
        write_d    = 1'b1;
      end
      S_BRANCH: load_pc_d = 1'b1;
      default: ;
    endcase
  end

  // Flags are evaluated live during the branch cycle so a preceding CMP is visible.
  always_comb begin
    case (exec_q[10:8])
      3'd0:    taken = 1'b1;
      3'd1:    taken = bus.Z_in;
      3'd2:    taken = ~bus.Z_in;
      3'd3:    taken = bus.N_in ^ bus.V_in;
      3'd4:    taken = (bus.N_in ^ bus.V_in) | bus.Z_in;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      ir_q        <= 16'd0;
      exec_q      <= 16'd0;
      w_q         <= 1'b1;
      readnum_q   <= 3'd0;
      writenum_q  <= 3'd0;
      write_q     <= 1'b0;
      loada_q     <= 1'b0;
      loadb_q     <= 1'b0;
      loadc_q     <= 1'b0;
      loads_q     <= 1'b0;
      asel_q      <= 1'b0;
      vsel_q      <= 2'b00;
      shift_q     <= 2'b00;
      aluop_q     <= 2'b00;
      load_pc_q   <= 1'b0;
      bad_instr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      exec_q      <= exec_d;
      w_q         <= w_d;
      readnum_q   <= readnum_d;
      writenum_q  <= writenum_d;
      write_q     <= write_d;
      loada_q     <= loada_d;
      loadb_q     <= loadb_d;
      loadc_q     <= loadc_d;
      loads_q     <= loads_d;
      asel_q      <= asel_d;
      vsel_q      <= vsel_d;
      shift_q     <= shift_d;
      aluop_q     <= aluop_d;
      load_pc_q   <= load_pc_d;
      bad_instr_q <= bad_instr_d;
    end
  end

  assign bus.w         = w_q;
  assign bus.readnum   = readnum_q;
  assign bus.writenum  = writenum_q;
  assign bus.write     = write_q;
  assign bus.loada     = loada_q;
  assign bus.loadb     = loadb_q;
  assign bus.loadc     = loadc_q;
  assign bus.loads     = loads_q;
  assign bus.asel      = asel_q;
  assign bus.bsel      = 1'b0;
  assign bus.vsel      = vsel_q;
  assign bus.shift     = shift_q;
  assign bus.ALUop     = aluop_q;
  assign bus.load_pc   = load_pc_q;
  assign bus.pc_sel    = load_pc_q & taken;
  assign bus.bad_instr = bad_instr_q;
  assign bus.sximm5    = {{11{ir_q[4]}}, ir_q[4:0]};
  assign bus.sximm8    = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_p6_controller.sv
// Scoreboard bench for p6_controller: an instruction-level model queues the expected
// control cycles and a negedge monitor pops and compares every active cycle.
module tb_p6_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  p6_controller_if bus();
  p6_controller dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel, shift, aluop;
    logic       load_pc, pc_sel, bad_instr;
  } ctl_t;

  typedef enum {K_MOVI, K_MOVR, K_ADD, K_AND, K_CMP, K_MVN, K_B, K_BAD} kind_t;

  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  ctl_t mon_act, mon_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.w = bus.w; c.readnum = bus.readnum; c.writenum = bus.writenum;
    c.write = bus.write; c.loada = bus.loada; c.loadb = bus.loadb;
    c.loadc = bus.loadc; c.loads = bus.loads; c.asel = bus.asel; c.bsel = bus.bsel;
    c.vsel = bus.vsel; c.shift = bus.shift; c.aluop = bus.ALUop;
    c.load_pc = bus.load_pc; c.pc_sel = bus.pc_sel; c.bad_instr = bus.bad_instr;
    return c;
  endfunction

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [15:0] ir);
    logic [2:0] opc; logic [1:0] op;
    opc = ir[15:13]; op = ir[12:11];
    if (opc == 3'b110 && op == 2'b10) return K_MOVI;
    if (opc == 3'b110 && op == 2'b00) return K_MOVR;
    if (opc == 3'b101 && op == 2'b00) return K_ADD;
    if (opc == 3'b101 && op == 2'b10) return K_AND;
    if (opc == 3'b101 && op == 2'b01) return K_CMP;
    if (opc == 3'b101 && op == 2'b11) return K_MVN;
    if (opc == 3'b001) return K_B;
    return K_BAD;
  endfunction

  function automatic ctl_t ev_read(input logic is_a, input logic [2:0] r);
    ctl_t c = '0;
    c.readnum = r;
    if (is_a) c.loada = 1'b1; else c.loadb = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ev_alu(input logic [1:0] sh, input logic [1:0] op, input logic a, input logic ld);
    ctl_t c = '0;
    c.loadc = 1'b1; c.shift = sh; c.aluop = op; c.asel = a; c.loads = ld;
    return c;
  endfunction

  function automatic ctl_t ev_write(input logic [2:0] r, input logic [1:0] vs);
    ctl_t c = '0;
    c.write = 1'b1; c.writenum = r; c.vsel = vs;
    return c;
  endfunction

  // Expected control cycles for one instruction; lat is the start-to-ready cycle count (0 = rejected).
  task automatic model(input logic [15:0] ir, input logic n, input logic v, input logic z, output int lat);
    logic [2:0] rn, rd, rm, cond;
    logic [1:0] sh, op;
    ctl_t c;
    bit tk, bad;
    rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0]; sh = ir[4:3]; op = ir[12:11]; cond = ir[10:8];
    case (classify(ir))
      K_MOVI: begin exp_q.push_back(ev_write(rn, 2'b01)); lat = 2; end
      K_MOVR: begin
        exp_q.push_back(ev_read(1'b0, rm));
        exp_q.push_back(ev_alu(sh, 2'b00, 1'b1, 1'b0));
        exp_q.push_back(ev_write(rd, 2'b00)); lat = 4;
      end
      K_ADD, K_AND: begin
        exp_q.push_back(ev_read(1'b1, rn));
        exp_q.push_back(ev_read(1'b0, rm));
        exp_q.push_back(ev_alu(sh, op, 1'b0, 1'b0));
        exp_q.push_back(ev_write(rd, 2'b00)); lat = 5;
      end
      K_CMP: begin
        exp_q.push_back(ev_read(1'b1, rn));
        exp_q.push_back(ev_read(1'b0, rm));
        exp_q.push_back(ev_alu(sh, 2'b01, 1'b0, 1'b1)); lat = 4;
      end
      K_MVN: begin
        exp_q.push_back(ev_read(1'b0, rm));
        exp_q.push_back(ev_alu(sh, 2'b11, 1'b0, 1'b0));
        exp_q.push_back(ev_write(rd, 2'b00)); lat = 4;
      end
      K_B: begin
        bad = 0;
        case (cond)
          3'd0: tk = 1;
          3'd1: tk = z;
          3'd2: tk = !z;
          3'd3: tk = (n != v);
          3'd4: tk = (n != v) || z;
          default: begin tk = 0; bad = 1; end
        endcase
        c = '0; c.load_pc = 1'b1; c.pc_sel = tk; c.bad_instr = bad;
        exp_q.push_back(c); lat = 2;
      end
      default: begin
        c = '0; c.w = 1'b1; c.bad_instr = 1'b1;
        exp_q.push_back(c); lat = 0;
      end
    endcase
  endtask

  function automatic logic [15:0] sext(input int val, input int bits);
    int x;
    x = val;
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return 16'(x);
  endfunction

  function automatic logic [15:0] gen_instr(input int k);
    logic [15:0] r;
    int b;
    r = 16'($urandom);
    case (k)
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:11] = 5'b10100;
      3: r[15:11] = 5'b10110;
      4: r[15:11] = 5'b10101;
      5: r[15:11] = 5'b10111;
      6: r[15:13] = 3'b001;
      default: begin
        b = $urandom_range(0, 6);
        case (b)
          0: r[15:13] = 3'b000;
          1: r[15:13] = 3'b010;
          2: r[15:13] = 3'b011;
          3: r[15:13] = 3'b100;
          4: r[15:13] = 3'b111;
          5: r[15:11] = 5'b11001;
          default: r[15:11] = 5'b11011;
        endcase
      end
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      mon_act = sample();
      if (mon_act.write | mon_act.loada | mon_act.loadb | mon_act.loadc |
          mon_act.loads | mon_act.load_pc | mon_act.bad_instr) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe actual=%h required=none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_bad++;
            $display("FAIL ctl_cycle actual=%h required=%h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input string name, input int lat);
    int n;
    n = 1;
    while (bus.w !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(name, n, lat);
  endtask

  task automatic load_ir(input logic [15:0] ir);
    bus.in = ir; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [15:0] ir, input logic n, input logic v, input logic z);
    int lat;
    load_ir(ir);
    bus.N_in = n; bus.V_in = v; bus.Z_in = z;
    model(ir, n, v, z, lat);
    bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    if (lat == 0) begin
      chk({name, "_stays_wait"}, bus.w, 1);
      tick();
    end else begin
      wait_ready({name, "_latency"}, lat);
    end
    $display("instr %s ir=%h nvz=%b%b%b lat=%0d", name, ir, n, v, z, lat);
  endtask

  initial begin
    ctl_t idle_c;
    int lat;
    bus.in = 16'd0; bus.load = 1'b0; bus.s = 1'b0;
    bus.N_in = 1'b0; bus.V_in = 1'b0; bus.Z_in = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    mon_en = 1'b1;

    idle_c = '0; idle_c.w = 1'b1;
    chk("reset_ctl", 32'(sample()), 32'(idle_c));
    chk("reset_ir", bus.sximm8, 16'h0000);

    load_ir(16'hD107);
    chk("sximm8_pos", bus.sximm8, sext(7, 8));
    run_instr("mov_imm7", 16'hD107, 0, 0, 0);
    load_ir(16'hD2FE);
    chk("sximm8_neg", bus.sximm8, sext(8'hFE, 8));
    load_ir(16'hD210);
    chk("sximm5_neg", bus.sximm5, sext(5'h10, 5));

    run_instr("add", 16'hA0A1, 0, 0, 0);
    run_instr("cmp", 16'hA902, 0, 0, 0);
    run_instr("mvn", 16'hB8E3, 0, 0, 0);
    run_instr("mov_reg", 16'hC04A, 0, 0, 0);
    run_instr("beq_t", 16'h2100, 0, 0, 1);
    run_instr("beq_nt", 16'h2100, 0, 0, 0);
    run_instr("blt_t", 16'h2300, 1, 0, 0);
    run_instr("ble_t", 16'h2400, 0, 0, 1);
    run_instr("bcond_bad", 16'h2700, 0, 0, 1);
    run_instr("op111", 16'hE000, 0, 0, 0);

    // Reset during GET_B of an ADD: only the first two cycles may appear.
    load_ir(16'hA0A1);
    model(16'hA0A1, 0, 0, 0, lat);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    bus.s = 1'b1; tick(); bus.s = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_w", bus.w, 1);
    chk("abort_ir", bus.sximm8, 16'h0000);
    repeat (6) tick();
    $display("instr abort_add ir=a0a1 reset in GET_B");

    // load while busy must not reach IR.
    load_ir(16'hA0A1);
    model(16'hA0A1, 0, 0, 0, lat);
    bus.s = 1'b1; tick(); bus.s = 1'b0;
    bus.in = 16'h1234; bus.load = 1'b1; tick(); bus.load = 1'b0;
    wait_ready("busy_load_latency", lat - 1);
    chk("busy_load_ir", bus.sximm8, sext(8'hA1, 8));
    $display("instr busy_load ir=a0a1");

    // load and s together: old IR runs, new IR is kept.
    load_ir(16'hD107);
    model(16'hD107, 0, 0, 0, lat);
    bus.in = 16'hD2FE; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    wait_ready("load_s_latency", lat);
    chk("load_s_new_ir", bus.sximm8, sext(8'hFE, 8));
    $display("instr load_and_start old=d107 new=d2fe");

    // s held high: two back-to-back MOV-imm executions.
    load_ir(16'hD305);
    model(16'hD305, 0, 0, 0, lat);
    model(16'hD305, 0, 0, 0, lat);
    bus.s = 1'b1;
    tick(); tick();
    chk("b2b_wait_gap", bus.w, 1);
    tick();
    chk("b2b_restart", bus.w, 0);
    tick();
    bus.s = 1'b0;
    tick();
    $display("instr back_to_back ir=d305 x2");

    for (int i = 0; i < 40; i++) begin
      run_instr("rand", gen_instr($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/p6_controller.md
Name: p6_controller

Overview:
Instruction register, decoder and control FSM that drives every control input of p6_datapath. It latches a 16-bit instruction and, on a start strobe, sequences the register file, the A/B/C registers, the ALU, the status register and the PC-load strobes. It also evaluates branch conditions from the datapath's N/V/Z flags. It is the command-issuing end of the datapath control interface; p6_datapath is the executing end.

Parameters:
None. The 16-bit ISA encoding is fixed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in  in  16  instruction word
- load  in  1  latch `in` into IR; honoured only while w=1
- s  in  1  start execution of the IR contents
- N_in, V_in, Z_in  in  1 each  status flags from the datapath
- w  out  1  idle/ready; high only in WAIT
- readnum, writenum  out  3 each  register-file addresses
- write, loada, loadb, loadc, loads  out  1 each  datapath enables
- asel, bsel  out  1 each  ALU operand selects
- vsel  out  2  write-back select: 00 = C feedback, 01 = sximm8
- shift, ALUop  out  2 each  shifter and ALU controls
- sximm5, sximm8  out  16 each  sign-extended IR[4:0] and IR[7:0]
- load_pc  out  1  PC update strobe
- pc_sel  out  1  1 = branch target, 0 = PC+1
- bad_instr  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (synchronous): state=WAIT, IR=0. On the next edge all enables are 0, w=1, bad_instr=0. A reset mid-instruction aborts it; no further write or load strobes are issued.
- IR field map: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], cond=IR[10:8].
- sximm5 and sximm8 are combinational from IR and are always valid.
- Outputs are Moore: decoded from state and IR only. Any output not named in a state is 0.
- States and their outputs:
  - WAIT: w=1.
  - WRITE_IMM: writenum=Rn, vsel=01, write=1.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=sh, loadc=1.
    - MOV-reg: asel=1, ALUop=00.
    - Otherwise: asel=0, ALUop=op.
    - CMP additionally asserts loads=1. No other instruction updates flags.
  - WRITE_REG: writenum=Rd, vsel=00, write=1.
  - BRANCH: load_pc=1, pc_sel=taken.
- Transitions from WAIT on s=1 (decode uses the IR value present that cycle):
  - opcode 110, op 10 (MOV Rn,#imm8): WRITE_IMM -> WAIT.
  - opcode 110, op 00 (MOV Rd,Rm{sh}): GET_B -> ALU -> WRITE_REG -> WAIT.
  - opcode 101, op 00/10 (ADD/AND): GET_A -> GET_B -> ALU -> WRITE_REG -> WAIT.
  - opcode 101, op 01 (CMP): GET_A -> GET_B -> ALU -> WAIT.
  - opcode 101, op 11 (MVN): GET_B -> ALU -> WRITE_REG -> WAIT.
  - opcode 001 (B-type): BRANCH -> WAIT.
  - Any other opcode/op: remain in WAIT and pulse bad_instr for 1 cycle.
- Branch condition `taken`:
  - cond 000 (B): 1
  - cond 001 (BEQ): Z
  - cond 010 (BNE): ~Z
  - cond 011 (BLT): N^V
  - cond 100 (BLE): (N^V)|Z
  - other cond values: not taken, and bad_instr pulses in BRANCH.
- Flags are sampled in BRANCH, so a CMP issued immediately before a branch is visible to it.
- s is ignored outside WAIT. s held high in WAIT starts back-to-back instructions with no idle cycle beyond WAIT itself.
- load while w=0 is ignored. load and s in the same WAIT cycle: execute the old IR; the new IR is latched at the same edge and is used by the next start.
- Latency from the s edge to w=1: MOV-imm 2, MOV-reg/MVN 4, ADD/AND 5, CMP 4, branch 2 cycles.

Test Plan:
- Reset, then load 0xD107 (MOV R1,#7) and pulse s: exactly one cycle with write=1, writenum=1, vsel=01, sximm8=0x0007; w high again 2 cycles after start.
- IR=0xD2FE (MOV R2,#-2): sximm8=0xFFFE. IR with imm5=0x10: sximm5=0xFFF0.
- IR=0xA0A1 (ADD R5,R0,R1):
  - loada with readnum=0, then loadb with readnum=1, then loadc with ALUop=00 and asel=0, then write with writenum=5 and vsel=00.
  - loads never asserted.
- IR=0xA9xx (CMP): loads=1 only in the ALU cycle; no write cycle; w returns after 4 cycles.
- Branches:
  - BEQ (0x21xx) with Z_in=1: load_pc=1, pc_sel=1. With Z_in=0: pc_sel=0.
  - BLT with N_in=1, V_in=0: pc_sel=1.
  - BLE with N_in=0, V_in=0, Z_in=1: pc_sel=1.
- Robustness:
  - Assert reset during GET_B of an ADD: next cycle w=1 and IR=0, and no write strobe follows.
  - Opcode 111 with s=1: bad_instr pulses once and the FSM stays in WAIT.
  - load during a busy cycle leaves IR unchanged.
